ctrl_pipe: RTL

//  Carries main-decoder control outputs from Decode through the D/E and E/M pipeline registers.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/ctrl_pipe_reg.sv | 24 ++
 rtl/ctrl_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, widths and bubble constants for the D/E and E/M
// pipeline registers.
package ctrl_pkg;

  localparam logic [4:0] RA_REG_DEF = 5'd31;

  // Controls latched at D/E; Rt/Rd travel along so E can pick the destination.
  typedef struct packed {
    logic       valid;
    logic       jump;
    logic       jalVal;
    logic       jalDst;
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic       signOrZero;
    logic       regDst;
    logic       regVal;
    logic [1:0] aluSrc;
    logic [1:0] pcBranchAddr;
    logic [1:0] aluOp;
    logic [1:0] maskOp;
    logic [4:0] rt;
    logic [4:0] rd;
  } ctrlE_t;

  typedef struct packed {
    logic       valid;
    logic       jump;
    logic       jalVal;
    logic       jalDst;
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic [1:0] maskOp;
    logic [4:0] writeReg;
  } ctrlM_t;

  localparam int CTRL_E_W = $bits(ctrlE_t);
  localparam int CTRL_M_W = $bits(ctrlM_t);

  localparam ctrlE_t BUBBLE_E = '0;
  localparam ctrlM_t BUBBLE_M = '0;

endpackage

// File: rtl/ctrl_pipe_reg.sv
// W-bit pipeline register with async reset, hold, and bubble-load.
// Hold has priority over bubble so a frozen stage never loses its contents.
module ctrl_pipe_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the pipeline samples its input from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= BUBBLE;
    else if (hold)   q <= q;
    else if (bubble) q <= BUBBLE;
    else             q <= d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder controls through D/E and E/M, resolves the Execute-stage
// destination register, and detects load-use hazards.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter logic [4:0] RA_REG      = RA_REG_DEF,
  parameter bit         LOAD_USE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StallM,
  input  logic       FlushE,
  input  logic       ValidD,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RdD,
  input  logic       JumpD,
  input  logic       JALValD,
  input  logic       JALDstD,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       MemToRegD,
  input  logic       SignOrZeroD,
  input  logic       RegDstD,
  input  logic       RegValD,
  input  logic [1:0] ALUSrcD,
  input  logic [1:0] PCBranchAddrD,
  input  logic [1:0] ALUOpD,
  input  logic [1:0] MaskOpD,
  output logic       SignOrZeroE,
  output logic       RegDstE,
  output logic       RegValE,
  output logic [1:0] ALUSrcE,
  output logic [1:0] PCBranchAddrE,
  output logic [1:0] ALUOpE,
  output logic [4:0] WriteRegE,
  output logic       JumpM,
  output logic       JALValM,
  output logic       JALDstM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemToRegM,
  output logic [1:0] MaskOpM,
  output logic [4:0] WriteRegM,
  output logic       ValidE,
  output logic       ValidM,
  output logic       StallD
);

  ctrlE_t dIn, eq;
  ctrlM_t mIn, mq;
  logic   flushPend, kill, hazard;

  assign dIn = '{valid: ValidD, jump: JumpD, jalVal: JALValD, jalDst: JALDstD,
                 regWrite: RegWriteD, memWrite: MemWriteD, memToReg: MemToRegD,
                 signOrZero: SignOrZeroD, regDst: RegDstD, regVal: RegValD,
                 aluSrc: ALUSrcD, pcBranchAddr: PCBranchAddrD, aluOp: ALUOpD,
                 maskOp: MaskOpD, rt: RtD, rd: RdD};

  assign WriteRegE = eq.jalDst ? RA_REG : (eq.regDst ? eq.rd : eq.rt);

  // A load in E whose result D needs must advance alone; r0 is never a real dependency.
  assign hazard = LOAD_USE_EN && eq.valid && eq.memToReg && eq.regWrite &&
                  (WriteRegE != 5'd0) && ValidD &&
                  ((WriteRegE == RsD) || (WriteRegE == RtD));

  assign StallD = hazard | StallM;
  assign kill   = FlushE | flushPend;

  // A redirect seen while memory is frozen is remembered until the first free edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         flushPend <= 1'b0;
    else if (StallM) flushPend <= flushPend | FlushE;
    else             flushPend <= 1'b0;
  end

  ctrl_pipe_reg #(.W(CTRL_E_W), .BUBBLE(BUBBLE_E)) deReg (
    .clk    (clk),
    .rst    (rst),
    .hold   (StallM),
    .bubble (kill | hazard | ~ValidD),
    .d      (dIn),
    .q      (eq)
  );

  assign mIn = '{valid: eq.valid, jump: eq.jump, jalVal: eq.jalVal,
                 jalDst: eq.jalDst, regWrite: eq.regWrite,
                 memWrite: eq.memWrite, memToReg: eq.memToReg,
                 maskOp: eq.maskOp, writeReg: WriteRegE};

  ctrl_pipe_reg #(.W(CTRL_M_W), .BUBBLE(BUBBLE_M)) emReg (
    .clk    (clk),
    .rst    (rst),
    .hold   (StallM),
    .bubble (1'b0),
    .d      (mIn),
    .q      (mq)
  );

  assign ValidE        = eq.valid;
  assign SignOrZeroE   = eq.signOrZero;
  assign RegDstE       = eq.regDst;
  assign RegValE       = eq.regVal;
  assign ALUSrcE       = eq.aluSrc;
  assign PCBranchAddrE = eq.pcBranchAddr;
  assign ALUOpE        = eq.aluOp;

  assign ValidM    = mq.valid;
  assign JumpM     = mq.jump;
  assign JALValM   = mq.jalVal;
  assign JALDstM   = mq.jalDst;
  assign RegWriteM = mq.regWrite;
  assign MemWriteM = mq.memWrite;
  assign MemToRegM = mq.memToReg;
  assign MaskOpM   = mq.maskOp;
  assign WriteRegM = mq.writeReg;

endmodule
